// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS-style controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP
    } state_t;

    // ALU operation codes (3-bit native width, zero-extended at the top)
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       illegal_op;
    } control_sig_t;

    // Quiescent control word: nothing enabled, ALU left on add
    function automatic control_sig_t ctl_idle();
        control_sig_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder_mc.sv
// Maps the R-type funct field onto a 3-bit ALU operation code.
// Latency: combinational.
// Backpressure: none; unknown funct reports funct_ok=0 and returns add.
module alu_decoder_mc
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_ok
);

    // funct lookup; anything outside the supported set is flagged
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_SLT: alu_op = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: FSM sequencing fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles with memory always ready.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold (outputs stable) until mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALUCTRL_W     = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem2reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_op
);

    state_t       state;
    state_t       state_nxt;
    control_sig_t ctl;
    logic [2:0]   funct_alu;
    logic         funct_ok;
    logic         mem_done;

    // Without the handshake every memory access completes in its first cycle
    assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

    alu_decoder_mc u_alu_decoder (
        .funct    (funct),
        .alu_op   (funct_alu),
        .funct_ok (funct_ok)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; reset blanks all outputs immediately
    always_comb begin
        state_nxt = state;
        ctl       = ctl_idle();
        case (state)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.pc_src    = PCSRC_ALU;
                // IR and PC commit only once the instruction word is back
                if (mem_done) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_en    = 1'b1;
                    state_nxt    = DECODE;
                end
            end
            DECODE: begin
                // Speculatively compute the branch target
                ctl.alu_src_b = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_J:         state_nxt = JUMP;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        state_nxt      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_nxt     = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_done) begin
                    state_nxt = MEMWB;
                end
            end
            MEMWB: begin
                ctl.reg_write = 1'b1;
                ctl.mem2reg   = 1'b1;
                state_nxt     = FETCH;
            end
            MEMWRITE: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (mem_done) begin
                    state_nxt = FETCH;
                end
            end
            EXECUTE: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                if (funct_ok) begin
                    ctl.alu_op = funct_alu;
                    state_nxt  = ALUWB;
                end else begin
                    ctl.illegal_op = 1'b1;
                    state_nxt      = FETCH;
                end
            end
            ALUWB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                state_nxt     = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALU_SUB;
                ctl.pc_src    = PCSRC_ALUOUT;
                // Taken only when the compare produced equality
                ctl.pc_en     = zero;
                state_nxt     = FETCH;
            end
            ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                state_nxt     = ADDIWB;
            end
            ADDIWB: begin
                ctl.reg_write = 1'b1;
                state_nxt     = FETCH;
            end
            JUMP: begin
                ctl.pc_en  = 1'b1;
                ctl.pc_src = PCSRC_JUMP;
                state_nxt  = FETCH;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
        if (reset) begin
            ctl = ctl_idle();
        end
    end

    assign pc_en       = ctl.pc_en;
    assign iord        = ctl.iord;
    assign ir_write    = ctl.ir_write;
    assign mem_read    = ctl.mem_read;
    assign mem_write   = ctl.mem_write;
    assign reg_write   = ctl.reg_write;
    assign reg_dst     = ctl.reg_dst;
    assign mem2reg     = ctl.mem2reg;
    assign alu_src_a   = ctl.alu_src_a;
    assign alu_src_b   = ctl.alu_src_b;
    assign pc_src      = ctl.pc_src;
    assign alu_control = ALUCTRL_W'(ctl.alu_op);
    assign illegal_op  = ctl.illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus random instruction stream.
// Latency: n/a.
// Backpressure: mem_ready stalls are injected on every memory step.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem2reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu;
        logic       illegal;
    } exp_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic zero = 1'b0, mem_ready = 1'b0;
    logic pc_en, iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem2reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic illegal_op;

    logic [5:0] op2 = 6'b000000, funct2 = 6'b101010;
    logic zero2 = 1'b0, mem_ready2 = 1'b0;
    logic pc_en2, iord2, ir_write2, mem_read2, mem_write2, reg_write2, reg_dst2, mem2reg2, alu_src_a2;
    logic [1:0] alu_src_b2, pc_src2;
    logic [4:0] alu_control2;
    logic illegal_op2;

    int n_cmp = 0;
    int n_bad = 0;
    int n_memwrite, n_illegal, n_regwrite;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control), .illegal_op(illegal_op)
    );

    multicycle_controller #(.ALUCTRL_W(5), .MEM_HANDSHAKE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .op(op2), .funct(funct2), .zero(zero2), .mem_ready(mem_ready2),
        .pc_en(pc_en2), .iord(iord2), .ir_write(ir_write2), .mem_read(mem_read2), .mem_write(mem_write2),
        .reg_write(reg_write2), .reg_dst(reg_dst2), .mem2reg(mem2reg2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .pc_src(pc_src2), .alu_control(alu_control2), .illegal_op(illegal_op2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t obs1();
        return {pc_en, iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem2reg,
                alu_src_a, alu_src_b, pc_src, alu_control, illegal_op};
    endfunction

    function automatic exp_t idle_w();
        exp_t e;
        e     = '0;
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic void ref_alu(input logic [5:0] f, output logic [2:0] code, output logic ok);
        ok = 1'b1;
        case (f)
            6'b100000: code = 3'b010;
            6'b100010: code = 3'b110;
            6'b100100: code = 3'b000;
            6'b100101: code = 3'b001;
            6'b101010: code = 3'b111;
            default: begin code = 3'b010; ok = 1'b0; end
        endcase
    endfunction

    // Expand one instruction into its expected per-step control words, then play it
    // against the DUT. A memory step that has not yet completed commits nothing.
    // stall_* < 0 selects random memory latency.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int stall_f, input int stall_m);
        exp_t steps[$];
        bit   is_mem[$];
        exp_t e;
        logic [2:0] code;
        logic ok;
        bit   known;
        op = o; funct = f; zero = z;
        n_memwrite = 0; n_illegal = 0; n_regwrite = 0;
        e = idle_w(); e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_en = 1;
        steps.push_back(e); is_mem.push_back(1);
        known = (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
        e = idle_w(); e.alu_src_b = 2'b11; e.illegal = !known;
        steps.push_back(e); is_mem.push_back(0);
        if (o == LW || o == SW) begin
            e = idle_w(); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            steps.push_back(e); is_mem.push_back(0);
            e = idle_w(); e.iord = 1;
            if (o == LW) e.mem_read = 1; else e.mem_write = 1;
            steps.push_back(e); is_mem.push_back(1);
            if (o == LW) begin
                e = idle_w(); e.reg_write = 1; e.mem2reg = 1;
                steps.push_back(e); is_mem.push_back(0);
            end
        end else if (o == RT) begin
            ref_alu(f, code, ok);
            e = idle_w(); e.alu_src_a = 1; e.alu = code; e.illegal = !ok;
            steps.push_back(e); is_mem.push_back(0);
            if (ok) begin
                e = idle_w(); e.reg_write = 1; e.reg_dst = 1;
                steps.push_back(e); is_mem.push_back(0);
            end
        end else if (o == BEQ) begin
            e = idle_w(); e.alu_src_a = 1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
            steps.push_back(e); is_mem.push_back(0);
        end else if (o == ADDI) begin
            e = idle_w(); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            steps.push_back(e); is_mem.push_back(0);
            e = idle_w(); e.reg_write = 1;
            steps.push_back(e); is_mem.push_back(0);
        end else if (o == JMP) begin
            e = idle_w(); e.pc_en = 1; e.pc_src = 2'b10;
            steps.push_back(e); is_mem.push_back(0);
        end
        foreach (steps[i]) begin
            int waits;
            int target;
            bit done;
            waits  = 0;
            target = (i == 0) ? stall_f : stall_m;
            forever begin
                if (!is_mem[i]) begin
                    done = 1;
                    mem_ready = 1'($urandom_range(0, 1));
                end else begin
                    if (target < 0) done = (waits >= 8) || ($urandom_range(0, 3) != 0);
                    else done = (waits >= target);
                    mem_ready = done;
                end
                e = steps[i];
                if (!done) begin e.ir_write = 0; e.pc_en = 0; end
                @(negedge clk);
                chk($sformatf("%s step%0d wait%0d", tag, i, waits), obs1(), e);
                if (mem_write) n_memwrite++;
                if (illegal_op) n_illegal++;
                if (reg_write) n_regwrite++;
                @(posedge clk); #1;
                if (done) break;
                waits++;
            end
        end
    endtask

    // Entered at a negedge inside FETCH; leaves at the negedge of the next FETCH.
    task automatic measure(input string tag, input logic [5:0] o, input logic [5:0] f, input int want);
        int n;
        op = o; funct = f; zero = 1'b1; mem_ready = 1'b1;
        n = 1;
        forever begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ir_write) break;
            n++;
            if (n > 20) break;
        end
        chk(tag, n, want);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] tab2 [10];
        logic [5:0] o, f;
        logic [5:0] legal_f [5];
        legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        tab2 = '{9'b1100_00010, 9'b0000_00010, 9'b0000_00111, 9'b0001_00010, 9'b1100_00010,
                 9'b0000_00010, 9'b0000_00010, 9'b0110_00010, 9'b0001_00010, 9'b1100_00010};

        // Reset state
        @(negedge clk);
        chk("reset outputs", obs1(), idle_w());
        chk("reset alu_control w5", alu_control2, 5'b00010);
        chk("reset mem_read w5", mem_read2, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed scenarios
        run_instr("lw", LW, 6'd0, 1'b0, 0, 0);
        chk("lw reg_write cycles", n_regwrite, 1);
        run_instr("beq taken", BEQ, 6'd0, 1'b1, 0, 0);
        run_instr("beq not taken", BEQ, 6'd0, 1'b0, 0, 0);
        run_instr("sw stall", SW, 6'd0, 1'b0, 0, 3);
        chk("sw mem_write cycles", n_memwrite, 4);
        run_instr("rtype bad funct", RT, 6'b100110, 1'b0, 0, 0);
        chk("bad funct illegal pulses", n_illegal, 1);
        chk("bad funct reg_write", n_regwrite, 0);
        run_instr("illegal op", 6'b111111, 6'd0, 1'b0, 2, 0);
        chk("illegal op pulses", n_illegal, 1);
        run_instr("fetch stall addi", ADDI, 6'd0, 1'b0, 2, 0);

        // Reset mid-wait in MEMREAD
        op = LW; funct = 6'd0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        begin
            exp_t e;
            e = idle_w(); e.mem_read = 1; e.iord = 1;
            chk("memread waiting", obs1(), e);
        end
        #1 reset = 1'b1;
        #1 chk("async reset outputs", obs1(), idle_w());
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("after reset", JMP, 6'd0, 1'b0, 0, 0);

        // Latency with memory always ready
        mem_ready = 1'b1;
        @(negedge clk);
        measure("lat lw", LW, 6'd0, 5);
        measure("lat sw", SW, 6'd0, 4);
        measure("lat rtype", RT, 6'b100000, 4);
        measure("lat addi", ADDI, 6'd0, 4);
        measure("lat beq", BEQ, 6'd0, 3);
        measure("lat j", JMP, 6'd0, 3);
        measure("lat illegal", 6'b010101, 6'd0, 2);
        mem_ready = 1'b0;
        @(posedge clk); #1;

        // Random instruction stream with random memory stalls
        for (int k = 0; k < 300; k++) begin
            f = legal_f[$urandom_range(0, 4)];
            case ($urandom_range(0, 7))
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = BEQ;
                4: o = ADDI;
                5: o = JMP;
                6: begin
                    o = 6'($urandom);
                    if (o == LW || o == SW || o == RT || o == BEQ || o == ADDI || o == JMP) o = 6'b111110;
                end
                default: begin o = RT; f = 6'($urandom); end
            endcase
            run_instr("rand", o, f, 1'($urandom_range(0, 1)), -1, -1);
        end

        // Wide ALU control, no memory handshake (mem_ready2 held low)
        reset = 1'b1;
        op2 = RT; funct2 = 6'b101010; mem_ready2 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("w5 nohs cycle%0d", c + 1),
                {ir_write2, mem_read2, iord2, reg_write2, alu_control2}, tab2[c]);
            @(posedge clk); #1;
            if (c == 4) op2 = LW;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
